// File: rtl/cc_pkg.sv
// Shared types and constants for the cache-controller reorder dispatch path.
// Line geometry, FSM state encoding and hit/miss flag values.
// Pure declarations; no logic.
package cc_pkg;

   // One cache line is BURST_LEN beats of BEAT_W bits; the default burst is 8 beats.
   localparam int BEAT_W     = 64;
   localparam int LINE_W     = BEAT_W * 8;
   localparam int OFS_W      = 6;
   localparam int HIT_DATA_W = OFS_W + LINE_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HIT_WR  = 2'd1,
      MISS_AR = 2'd2
   } cc_disp_state_t;

   localparam logic CC_FLAG_HIT  = 1'b1;
   localparam logic CC_FLAG_MISS = 1'b0;

endpackage

// File: rtl/cc_reorder_dispatch.sv
// Purpose: routes tag-lookup results to the reorder unit (flag/data FIFOs) or to memory as line reads.
// Latency: hit -> FIFO writes 1 cycle after accept; miss -> flag + arvalid 1 cycle after accept.
// Backpressure: lkup_ready_o drops while a lookup is in flight, on either FIFO almost-full, or at the miss limit.
module cc_reorder_dispatch
   import cc_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int MAX_OUTSTANDING = 4,
   parameter int BURST_LEN       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lkup_valid_i,
   output logic                  lkup_ready_o,
   input  logic                  lkup_hit_i,
   input  logic [ADDR_W-1:0]     lkup_addr_i,
   input  logic [LINE_W-1:0]     lkup_data_i,
   input  logic                  hit_flag_fifo_afull_i,
   output logic                  hit_flag_fifo_wren_o,
   output logic                  hit_flag_fifo_wdata_o,
   input  logic                  hit_data_fifo_afull_i,
   output logic                  hit_data_fifo_wren_o,
   output logic [HIT_DATA_W-1:0] hit_data_fifo_wdata_o,
   output logic                  mem_arvalid_o,
   input  logic                  mem_arready_i,
   output logic [ADDR_W-1:0]     mem_araddr_o,
   output logic [7:0]            mem_arlen_o,
   input  logic                  mem_rvalid_i,
   input  logic                  mem_rready_i,
   input  logic                  mem_rlast_i,
   output logic [3:0]            outstanding_o
);

   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

   cc_disp_state_t        state_q;
   logic [3:0]            outstanding_q;
   logic [3:0]            outstanding_d;
   logic                  flag_wren_q;
   logic                  flag_wdata_q;
   logic                  data_wren_q;
   logic [HIT_DATA_W-1:0] data_wdata_q;
   logic                  arvalid_q;
   logic [ADDR_W-1:0]     araddr_q;

   logic accept;
   logic miss_accept;
   logic line_done;

   // Ready is deliberately conservative: it ignores hit/miss so that it never depends on lkup_valid_i.
   assign lkup_ready_o = (state_q == IDLE) & ~hit_flag_fifo_afull_i & ~hit_data_fifo_afull_i
                         & (outstanding_q < MAX_OUT);
   assign accept       = lkup_valid_i & lkup_ready_o;
   assign miss_accept  = accept & ~lkup_hit_i;
   // Only a final beat that is really taken by the reorder unit retires a miss; retiring at zero is ignored.
   assign line_done    = mem_rvalid_i & mem_rready_i & mem_rlast_i & (outstanding_q != 4'd0);

   assign hit_flag_fifo_wren_o  = flag_wren_q;
   assign hit_flag_fifo_wdata_o = flag_wdata_q;
   assign hit_data_fifo_wren_o  = data_wren_q;
   assign hit_data_fifo_wdata_o = data_wdata_q;
   assign mem_arvalid_o         = arvalid_q;
   assign mem_araddr_o          = araddr_q;
   assign mem_arlen_o           = 8'(BURST_LEN - 1);
   assign outstanding_o         = outstanding_q;

   // Next in-flight miss count: an issue and a retire in the same cycle cancel out.
   always_comb begin
      outstanding_d = outstanding_q;
      if (miss_accept && !line_done) begin
         outstanding_d = outstanding_q + 4'd1;
      end else if (!miss_accept && line_done) begin
         outstanding_d = outstanding_q - 4'd1;
      end
   end

   // In-flight miss counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding_q <= 4'd0;
      end else begin
         outstanding_q <= outstanding_d;
      end
   end

   // Dispatch FSM: the accepted lookup is captured straight into the registered FIFO/AR outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         flag_wren_q  <= 1'b0;
         flag_wdata_q <= 1'b0;
         data_wren_q  <= 1'b0;
         data_wdata_q <= '0;
         arvalid_q    <= 1'b0;
         araddr_q     <= '0;
      end else begin
         // FIFO write strobes are single-cycle pulses.
         flag_wren_q <= 1'b0;
         data_wren_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  flag_wren_q <= 1'b1;
                  if (lkup_hit_i) begin
                     state_q      <= HIT_WR;
                     flag_wdata_q <= CC_FLAG_HIT;
                     data_wren_q  <= 1'b1;
                     data_wdata_q <= {lkup_addr_i[OFS_W-1:0], lkup_data_i};
                  end else begin
                     state_q      <= MISS_AR;
                     flag_wdata_q <= CC_FLAG_MISS;
                     arvalid_q    <= 1'b1;
                     araddr_q     <= {lkup_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                  end
               end
            end
            HIT_WR: begin
               state_q <= IDLE;
            end
            MISS_AR: begin
               // arvalid stays high with a stable address until memory takes it.
               if (mem_arready_i) begin
                  arvalid_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               arvalid_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cc_reorder_dispatch.sv
// Self-checking bench for cc_reorder_dispatch: directed scenarios, then randomized traffic.
// A cycle-level behavioural model predicts ready, FIFO writes, read requests and the miss count.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.
module tb_cc_reorder_dispatch;

   localparam int MAXO = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         lkup_valid, lkup_ready, lkup_hit;
   logic [31:0]  lkup_addr;
   logic [511:0] lkup_data;
   logic         fafull, f_wren, f_wdata;
   logic         dafull, d_wren;
   logic [517:0] d_wdata;
   logic         arvalid, arready;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic         rvalid, rready, rlast;
   logic [3:0]   outst;

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural model: at most one lookup pending, plus an integer miss count.
   bit           m_busy, m_hit, m_first, m_acc, exp_rdy, rdone;
   logic [31:0]  m_addr;
   logic [511:0] m_data;
   int           m_out;

   logic [511:0] pat;
   int           w;

   always #5 clk = ~clk;

   cc_reorder_dispatch dut (
      .clk                   (clk),
      .rst                   (rst),
      .lkup_valid_i          (lkup_valid),
      .lkup_ready_o          (lkup_ready),
      .lkup_hit_i            (lkup_hit),
      .lkup_addr_i           (lkup_addr),
      .lkup_data_i           (lkup_data),
      .hit_flag_fifo_afull_i (fafull),
      .hit_flag_fifo_wren_o  (f_wren),
      .hit_flag_fifo_wdata_o (f_wdata),
      .hit_data_fifo_afull_i (dafull),
      .hit_data_fifo_wren_o  (d_wren),
      .hit_data_fifo_wdata_o (d_wdata),
      .mem_arvalid_o         (arvalid),
      .mem_arready_i         (arready),
      .mem_araddr_o          (araddr),
      .mem_arlen_o           (arlen),
      .mem_rvalid_i          (rvalid),
      .mem_rready_i          (rready),
      .mem_rlast_i           (rlast),
      .outstanding_o         (outst)
   );

   task automatic chk(input string tag, input logic [517:0] got, input logic [517:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Present a lookup and hold it until accepted; returns 1 ns into the cycle after the accept edge.
   task automatic send(input logic hit, input logic [31:0] addr, input logic [511:0] data,
                       output int waits);
      bit got;
      got        = 1'b0;
      waits      = 0;
      lkup_valid = 1'b1;
      lkup_hit   = hit;
      lkup_addr  = addr;
      lkup_data  = data;
      for (int n = 0; n < 100 && !got; n++) begin
         @(negedge clk);
         if (lkup_ready) got = 1'b1;
         else waits++;
      end
      if (!got) chk("send_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      lkup_valid = 1'b0;
   endtask

   task automatic pulse_rlast();
      rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
      @(posedge clk);
      #1;
      rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
   endtask

   // Reference model: check every cycle, then advance by the handshakes seen this cycle.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_flag_wren", f_wren, 1'b0);
         chk("rst_flag_wdata", f_wdata, 1'b0);
         chk("rst_data_wren", d_wren, 1'b0);
         chk("rst_data_wdata", d_wdata, '0);
         chk("rst_arvalid", arvalid, 1'b0);
         chk("rst_araddr", araddr, 32'h0);
         chk("rst_arlen", arlen, 8'd7);
         chk("rst_outstanding", outst, 4'd0);
         m_busy = 1'b0; m_first = 1'b0; m_acc = 1'b0; m_out = 0;
      end else begin
         exp_rdy = !m_busy && !fafull && !dafull && (m_out < MAXO);
         chk("ready", lkup_ready, exp_rdy);
         chk("outstanding", outst, m_out);
         chk("arlen", arlen, 8'd7);
         if (m_busy && m_hit) begin
            chk("hit_flag_wren", f_wren, 1'b1);
            chk("hit_flag_wdata", f_wdata, 1'b1);
            chk("hit_data_wren", d_wren, 1'b1);
            chk("hit_data_wdata", d_wdata, {m_addr[5:0], m_data});
            chk("hit_arvalid", arvalid, 1'b0);
         end else if (m_busy) begin
            chk("miss_flag_wren", f_wren, m_first);
            if (m_first) chk("miss_flag_wdata", f_wdata, 1'b0);
            chk("miss_data_wren", d_wren, 1'b0);
            chk("miss_arvalid", arvalid, 1'b1);
            chk("miss_araddr", araddr, m_addr & 32'hFFFF_FFC0);
         end else begin
            chk("idle_flag_wren", f_wren, 1'b0);
            chk("idle_data_wren", d_wren, 1'b0);
            chk("idle_arvalid", arvalid, 1'b0);
         end
         rdone = rvalid && rready && rlast;
         m_acc = lkup_valid && exp_rdy;
         if (m_busy) begin
            if (m_hit) m_busy = 1'b0;
            else begin
               m_first = 1'b0;
               if (arready) m_busy = 1'b0;
            end
         end
         if (m_acc) begin
            m_busy = 1'b1; m_first = 1'b1;
            m_hit = lkup_hit; m_addr = lkup_addr; m_data = lkup_data;
         end
         m_out = m_out + ((m_acc && !lkup_hit) ? 1 : 0) - ((rdone && m_out > 0) ? 1 : 0);
      end
   end

   initial begin
      rst = 1'b1;
      lkup_valid = 1'b0; lkup_hit = 1'b0; lkup_addr = '0; lkup_data = '0;
      fafull = 1'b0; dafull = 1'b0; arready = 1'b0;
      rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", lkup_ready, 1'b1);
      @(posedge clk);
      #1;

      // Hit at 0x1048: both FIFO writes one cycle after accept.
      for (int i = 0; i < 8; i++) pat[64*i +: 64] = 64'hA5A5_0000_0000_0001 + 64'(i);
      send(1'b1, 32'h0000_1048, pat, w);
      chk("t1_flag_wren", f_wren, 1'b1);
      chk("t1_flag_wdata", f_wdata, 1'b1);
      chk("t1_data_wren", d_wren, 1'b1);
      chk("t1_ofs", d_wdata[517:512], 6'h08);
      chk("t1_line", d_wdata[511:0], pat);
      chk("t1_ready_low", lkup_ready, 1'b0);
      @(posedge clk);
      #1;

      // Miss at 0x2064 with arready withheld for the first two cycles of the request.
      arready = 1'b0;
      send(1'b0, 32'h0000_2064, rand512(), w);
      chk("t2_flag_wren", f_wren, 1'b1);
      chk("t2_flag_wdata", f_wdata, 1'b0);
      chk("t2_arvalid", arvalid, 1'b1);
      chk("t2_araddr", araddr, 32'h0000_2040);
      chk("t2_arlen", arlen, 8'd7);
      chk("t2_outstanding", outst, 4'd1);
      @(posedge clk);
      #1;
      chk("t2_flag_once", f_wren, 1'b0);
      chk("t2_arvalid_held", arvalid, 1'b1);
      @(posedge clk);
      #1;
      chk("t2_arvalid_held3", arvalid, 1'b1);
      chk("t2_araddr_stable", araddr, 32'h0000_2040);
      arready = 1'b1;
      @(posedge clk);
      #1;
      arready = 1'b0;
      chk("t2_arvalid_done", arvalid, 1'b0);
      chk("t2_ready_back", lkup_ready, 1'b1);

      // Drain, then four back-to-back misses up to the limit.
      pulse_rlast();
      chk("t3_drained", outst, 4'd0);
      arready = 1'b1;
      for (int i = 0; i < 4; i++) send(1'b0, $urandom, rand512(), w);
      @(posedge clk);
      #1;
      chk("t3_outstanding_max", outst, 4'd4);
      chk("t3_ready_blocked", lkup_ready, 1'b0);
      pulse_rlast();
      chk("t3_outstanding_3", outst, 4'd3);
      chk("t3_ready_again", lkup_ready, 1'b1);

      // Miss accept on the same edge as a retiring read, starting from 2.
      pulse_rlast();
      chk("t4_outstanding_2", outst, 4'd2);
      rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
      send(1'b0, 32'h0000_4000, rand512(), w);
      rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
      chk("t4_no_wait", w, 0);
      chk("t4_simul", outst, 4'd2);
      @(posedge clk);
      #1;

      // Data FIFO almost full blocks a pending hit.
      dafull = 1'b1;
      lkup_valid = 1'b1; lkup_hit = 1'b1; lkup_addr = 32'h0000_5010; lkup_data = rand512();
      repeat (3) begin
         @(negedge clk);
         chk("t5_ready_low", lkup_ready, 1'b0);
         chk("t5_no_flag", f_wren, 1'b0);
         chk("t5_no_data", d_wren, 1'b0);
      end
      @(posedge clk);
      #1 dafull = 1'b0;
      send(1'b1, lkup_addr, lkup_data, w);
      chk("t5_accept_next", w, 0);
      chk("t5_data_wren", d_wren, 1'b1);
      @(posedge clk);
      #1;

      // Reset in the middle of a pending read request.
      arready = 1'b0;
      send(1'b0, 32'h3000_0080, rand512(), w);
      chk("t6_arvalid", arvalid, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("t6_arvalid_rst", arvalid, 1'b0);
      chk("t6_flag_rst", f_wren, 1'b0);
      chk("t6_outstanding_rst", outst, 4'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_ready_idle", lkup_ready, 1'b1);
      chk("t6_arvalid_idle", arvalid, 1'b0);

      // Randomized traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk);
         #1;
         if (lkup_valid && m_acc) lkup_valid = 1'b0;
         if (!lkup_valid && $urandom_range(0, 1) == 0) begin
            lkup_valid = 1'b1;
            lkup_hit   = 1'($urandom_range(0, 1));
            lkup_addr  = $urandom;
            lkup_data  = rand512();
         end
         arready = ($urandom_range(0, 2) != 0);
         fafull  = ($urandom_range(0, 7) == 0);
         dafull  = ($urandom_range(0, 7) == 0);
         rvalid  = ($urandom_range(0, 3) == 0);
         rready  = ($urandom_range(0, 3) != 0);
         rlast   = ($urandom_range(0, 1) == 0);
      end
      @(posedge clk);
      #1;
      if (lkup_valid && m_acc) lkup_valid = 1'b0;
      lkup_valid = 1'b0; arready = 1'b1; fafull = 1'b0; dafull = 1'b0;
      rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
